// File: rtl/regsel_pkg.sv
// Shared types and helpers for the register-select pipeline: source-select encodings,
// select/source width helpers and the hazard FSM states.
package regsel_pkg;

  localparam int   OE_SRC_USEQ   = 0;
  localparam logic LOAD_SRC_USEQ = 1'b0;
  localparam logic LOAD_SRC_OP0  = 1'b1;

  typedef enum logic {IDLE, PEND} hazState_t;

  // Widths never collapse to zero, even for degenerate counts.
  function automatic int selWidth(input int regCount);
    return (regCount > 1) ? $clog2(regCount) : 1;
  endfunction

  function automatic int srcWidth(input int opCount);
    return (opCount > 0) ? $clog2(opCount + 1) : 1;
  endfunction

endpackage

// File: rtl/regsel_scoreboard.sv
// Read-after-write interlock: remembers the last loaded register for WB_LAT cycles
// and flags an oe to that register while the write-back is still pending.
module regsel_scoreboard
  import regsel_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int WB_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             loadAcc,
  input  logic [SEL_W-1:0] loadSel,
  input  logic             oeReq,
  input  logic [SEL_W-1:0] oeSel,
  output logic             hazard
);

  hazState_t        state;
  logic [3:0]       cnt;
  logic [SEL_W-1:0] pendReg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pendReg <= '0;
    end else if (loadAcc) begin
      // A fresh load always (re)starts the window, replacing any older pending register.
      state   <= PEND;
      cnt     <= 4'(WB_LAT);
      pendReg <= loadSel;
    end else if (state == PEND) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) state <= IDLE;
    end
  end

  // Uses pre-edge state, so a same-cycle oe+load to one register still reads.
  assign hazard = (state == PEND) && oeReq && (oeSel == pendReg);

endmodule

// File: rtl/regsel_pipe.sv
// Register output-enable / load decoder with one-cycle registered outputs.
// Define REGSEL_HAZARD_EN to build the read-after-write interlock (stall).
module regsel_pipe
  import regsel_pkg::*;
#(
  parameter  int REG_COUNT = 8,
  parameter  int OP_COUNT  = 3,
  parameter  int WB_LAT    = 1,
  localparam int SEL_W     = selWidth(REG_COUNT),
  localparam int SRC_W     = srcWidth(OP_COUNT)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ir_load,
  input  logic [OP_COUNT*SEL_W-1:0] op_in,
  input  logic                      oe,
  input  logic                      load,
  input  logic [SRC_W-1:0]          oe_src,
  input  logic                      load_src,
  input  logic [SEL_W-1:0]          useq_sel_oe,
  input  logic [SEL_W-1:0]          useq_sel_load,
  output logic [REG_COUNT-1:0]      reg_oes,
  output logic [REG_COUNT-1:0]      reg_not_loads,
  output logic                      stall,
  output logic                      sel_err
);

  localparam logic [SEL_W:0] REG_LIM = (SEL_W + 1)'(REG_COUNT);

  logic [OP_COUNT-1:0][SEL_W-1:0] ops;
  logic [SEL_W-1:0]               oeSel, loadSel;
  logic                           oeSrcBad, oeOk, loadOk, oeReq, loadAcc, hazard;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        ops <= '0;
    else if (ir_load) ops <= op_in;
  end

  always_comb begin
    oeSel    = useq_sel_oe;
    oeSrcBad = (oe_src > SRC_W'(OP_COUNT));
    for (int k = 1; k <= OP_COUNT; k++)
      if (oe_src == SRC_W'(k)) oeSel = ops[k-1];
    loadSel = (load_src == LOAD_SRC_OP0) ? ops[0] : useq_sel_load;
  end

  assign oeOk    = !oeSrcBad && ({1'b0, oeSel} < REG_LIM);
  assign loadOk  = ({1'b0, loadSel} < REG_LIM);
  assign oeReq   = oe && oeOk;
  assign loadAcc = load && loadOk;

`ifdef REGSEL_HAZARD_EN
  regsel_scoreboard #(.SEL_W(SEL_W), .WB_LAT(WB_LAT)) uScoreboard (
    .clock   (clock),
    .reset   (reset),
    .loadAcc (loadAcc),
    .loadSel (loadSel),
    .oeReq   (oeReq),
    .oeSel   (oeSel),
    .hazard  (hazard)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall <= 1'b0;
    else       stall <= hazard;
  end
`else
  assign hazard = 1'b0;
  assign stall  = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_oes       <= '0;
      reg_not_loads <= '1;
      sel_err       <= 1'b0;
    end else begin
      reg_oes       <= (oeReq && !hazard) ? (REG_COUNT'(1) << oeSel) : '0;
      reg_not_loads <= loadAcc ? ~(REG_COUNT'(1) << loadSel) : '1;
      sel_err       <= sel_err | (oe && !oeOk) | (load && !loadOk);
    end
  end

endmodule

// File: tb/tb_regsel_pipe.sv
// Self-checking bench for regsel_pipe: table-driven decode vectors plus hand-written
// interlock, out-of-range and async-reset sequences; expectations flow through a queue.
module tb_regsel_pipe;

`ifdef REGSEL_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset, reset6, ir_load, oe, load, load_src;
  logic [8:0] op_in;
  logic [1:0] oe_src;
  logic [2:0] useq_sel_oe, useq_sel_load;
  logic [7:0] reg_oes, reg_not_loads;
  logic       stall, sel_err;
  logic [5:0] oes6, nl6;
  logic       stall6, err6;

  always #5 clock = ~clock;

  regsel_pipe #(.REG_COUNT(8), .OP_COUNT(3), .WB_LAT(2)) dut (
    .clock(clock), .reset(reset), .ir_load(ir_load), .op_in(op_in),
    .oe(oe), .load(load), .oe_src(oe_src), .load_src(load_src),
    .useq_sel_oe(useq_sel_oe), .useq_sel_load(useq_sel_load),
    .reg_oes(reg_oes), .reg_not_loads(reg_not_loads), .stall(stall), .sel_err(sel_err)
  );

  regsel_pipe #(.REG_COUNT(6), .OP_COUNT(3), .WB_LAT(2)) dut6 (
    .clock(clock), .reset(reset6), .ir_load(ir_load), .op_in(op_in),
    .oe(oe), .load(load), .oe_src(oe_src), .load_src(load_src),
    .useq_sel_oe(useq_sel_oe), .useq_sel_load(useq_sel_load),
    .reg_oes(oes6), .reg_not_loads(nl6), .stall(stall6), .sel_err(err6)
  );

  typedef struct {
    logic [7:0] oes;
    logic [7:0] nl;
    logic       st;
    string      name;
  } exp_t;

  typedef struct {
    logic       irl;
    logic [8:0] op;
    logic       oe;
    logic [1:0] src;
    logic [2:0] uo;
    logic       ld;
    logic       ls;
    logic [2:0] ul;
    logic [7:0] eo;
    logic [7:0] en;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[15];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Queue the expectation, let one edge pass, then compare what the DUT produced.
  task automatic cyc(input logic [7:0] eo, input logic [7:0] en, input logic es, input string nm);
    exp_t e;
    e.oes = eo; e.nl = en; e.st = es; e.name = nm;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      chk({e.name, ".oes"}, 32'(reg_oes), 32'(e.oes));
      chk({e.name, ".nl"}, 32'(reg_not_loads), 32'(e.nl));
      chk({e.name, ".stall"}, 32'(stall), 32'(e.st));
      chk({e.name, ".err"}, 32'(sel_err), 32'd0);
    end
  endtask

  task automatic setIn(input logic o, input logic [1:0] s, input logic [2:0] uo,
                       input logic l, input logic ls, input logic [2:0] ul);
    ir_load = 1'b0; oe = o; oe_src = s; useq_sel_oe = uo;
    load = l; load_src = ls; useq_sel_load = ul;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 9'h1D9, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF};
    tbl[1]  = '{1'b0, 9'h000, 1'b1, 2'd0, 3'd2, 1'b0, 1'b0, 3'd0, 8'h04, 8'hFF};
    tbl[2]  = '{1'b0, 9'h000, 1'b1, 2'd1, 3'd2, 1'b0, 1'b0, 3'd0, 8'h02, 8'hFF};
    tbl[3]  = '{1'b0, 9'h000, 1'b1, 2'd2, 3'd2, 1'b0, 1'b0, 3'd0, 8'h08, 8'hFF};
    tbl[4]  = '{1'b0, 9'h000, 1'b1, 2'd3, 3'd2, 1'b0, 1'b0, 3'd0, 8'h80, 8'hFF};
    tbl[5]  = '{1'b0, 9'h000, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 3'd5, 8'h00, 8'hDF};
    tbl[6]  = '{1'b0, 9'h000, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1, 3'd5, 8'h00, 8'hFD};
    tbl[7]  = '{1'b0, 9'h000, 1'b1, 2'd0, 3'd4, 1'b0, 1'b0, 3'd0, 8'h10, 8'hFF};
    tbl[8]  = '{1'b0, 9'h000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF};
    tbl[9]  = '{1'b1, 9'h006, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 3'd0, 8'h02, 8'hFF};
    tbl[10] = '{1'b0, 9'h000, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0, 3'd0, 8'h40, 8'hFF};
    tbl[11] = '{1'b1, 9'h1D9, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF};
    tbl[12] = '{1'b0, 9'h000, 1'b1, 2'd0, 3'd0, 1'b1, 1'b0, 3'd2, 8'h01, 8'hFB};
    tbl[13] = '{1'b0, 9'h000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF};
    tbl[14] = '{1'b0, 9'h000, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF};

    reset = 1'b1; reset6 = 1'b1; op_in = '0;
    setIn(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst.oes", 32'(reg_oes), 32'h00);
    chk("rst.nl", 32'(reg_not_loads), 32'hFF);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.err", 32'(sel_err), 32'd0);
    chk("rst6.nl", 32'(nl6), 32'h3F);
    chk("rst6.err", 32'(err6), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      ir_load = tbl[i].irl; op_in = tbl[i].op; oe = tbl[i].oe; oe_src = tbl[i].src;
      useq_sel_oe = tbl[i].uo; load = tbl[i].ld; load_src = tbl[i].ls;
      useq_sel_load = tbl[i].ul;
      cyc(tbl[i].eo, tbl[i].en, 1'b0, $sformatf("vec%0d", i));
    end

    // Interlock: load r3, then read r3 three times.
    setIn(1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 3'd3); cyc(8'h00, 8'hF7, 1'b0, "raw.load");
    setIn(1'b1, 2'd0, 3'd3, 1'b0, 1'b0, 3'd0);
    cyc(HAZ ? 8'h00 : 8'h08, 8'hFF, HAZ, "raw.rd1");
    cyc(HAZ ? 8'h00 : 8'h08, 8'hFF, HAZ, "raw.rd2");
    cyc(8'h08, 8'hFF, 1'b0, "raw.rd3");
    // Another register in the same window never stalls.
    setIn(1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 3'd3); cyc(8'h00, 8'hF7, 1'b0, "oth.load");
    setIn(1'b1, 2'd0, 3'd4, 1'b0, 1'b0, 3'd0);
    cyc(8'h10, 8'hFF, 1'b0, "oth.rd1");
    cyc(8'h10, 8'hFF, 1'b0, "oth.rd2");

    // Same-cycle read and load of r3: read proceeds, window starts.
    setIn(1'b1, 2'd0, 3'd3, 1'b1, 1'b0, 3'd3); cyc(8'h08, 8'hF7, 1'b0, "same.rdld");
    setIn(1'b1, 2'd0, 3'd3, 1'b0, 1'b0, 3'd0);
    cyc(HAZ ? 8'h00 : 8'h08, 8'hFF, HAZ, "same.rd1");
    cyc(HAZ ? 8'h00 : 8'h08, 8'hFF, HAZ, "same.rd2");
    cyc(8'h08, 8'hFF, 1'b0, "same.rd3");

    // Out-of-range select on the 6-register instance.
    reset6 = 1'b0;
    setIn(1'b1, 2'd0, 3'd5, 1'b0, 1'b0, 3'd0); cyc(8'h20, 8'hFF, 1'b0, "oor.in");
    chk("oor6.in.oes", 32'(oes6), 32'h20);
    chk("oor6.in.err", 32'(err6), 32'd0);
    setIn(1'b1, 2'd0, 3'd7, 1'b0, 1'b0, 3'd0); cyc(8'h80, 8'hFF, 1'b0, "oor.bad");
    chk("oor6.bad.oes", 32'(oes6), 32'h00);
    chk("oor6.bad.err", 32'(err6), 32'd1);
    setIn(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(8'h00, 8'hFF, 1'b0, $sformatf("oor.hold%0d", i));
      chk($sformatf("oor6.hold%0d.err", i), 32'(err6), 32'd1);
      chk($sformatf("oor6.hold%0d.st", i), 32'(stall6), 32'd0);
    end
    reset6 = 1'b1; #1;
    chk("oor6.rst.err", 32'(err6), 32'd0);
    reset6 = 1'b0;

    // Async reset in the middle of a pending window.
    setIn(1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 3'd3); cyc(8'h00, 8'hF7, 1'b0, "ar.load");
    setIn(1'b1, 2'd0, 3'd3, 1'b0, 1'b0, 3'd0);
    cyc(HAZ ? 8'h00 : 8'h08, 8'hFF, HAZ, "ar.rd1");
    #2 reset = 1'b1;
    #1;
    chk("ar.now.oes", 32'(reg_oes), 32'h00);
    chk("ar.now.nl", 32'(reg_not_loads), 32'hFF);
    chk("ar.now.stall", 32'(stall), 32'd0);
    chk("ar.now.err", 32'(sel_err), 32'd0);
    #1 reset = 1'b0;
    cyc(8'h08, 8'hFF, 1'b0, "ar.rd2");
    setIn(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    cyc(8'h00, 8'hFF, 1'b0, "ar.idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
